ofmap_writer_param_2: RTL and testbench

//  Write-side counterpart of the conv input address generator. It accepts the

---
 rtl/ofmap_writer_param_2_if.sv | 38 +++
 rtl/ofmap_writer_param_2.sv | 171 +++++++++++++++++
 tb/tb_ofmap_writer_param_2.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ofmap_writer_param_2_if.sv
// ---------------------------------------------------------------------------
// ofmap_writer_param_2_if
// Bundles the two buses of the output feature-map writer:
//   - result stream : in_valid / in_data (producer -> writer), in_ready back
//   - RAM write bus : we / waddr / wdata (writer -> output feature-map RAM)
// Modports
//   master : the result producer / RAM side (drives in_valid, in_data)
//   slave  : the writer itself (drives in_ready, we, waddr, wdata)
// ---------------------------------------------------------------------------
interface ofmap_writer_param_2_if #(
   parameter int DATA_WIDTH     = 16,
   parameter int OUT_ADDR_WIDTH = 10
);
   logic                      in_valid;
   logic [DATA_WIDTH-1:0]     in_data;
   logic                      in_ready;
   logic                      we;
   logic [OUT_ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0]     wdata;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  we,
      input  waddr,
      input  wdata
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output we,
      output waddr,
      output wdata
   );
endinterface

// File: rtl/ofmap_writer_param_2.sv
// ---------------------------------------------------------------------------
// ofmap_writer_param_2
// Write-side counterpart of the conv input address generator. Accepts conv /
// pool results over a valid/ready stream and turns each accepted word into a
// registered RAM write. Pixels are laid out row-major inside a map and maps
// are stacked back to back, so the address of a pixel is
//    map*W*W + row*W + col      (W = OUT_FEATURE_WIDTH)
// done is raised together with the write of the last pixel of the last map
// and held until the next start.
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-high
//   start               begin a new frame (honoured in IDLE or DONE only)
//   bus.in_valid        result word available
//   bus.in_data         result word, two's complement
//   bus.in_ready        writer accepts a word this cycle (state == WRITE)
//   bus.we              RAM write enable, one cycle after accept
//   bus.waddr           RAM write address (holds when we = 0)
//   bus.wdata           RAM write data, ReLU-clamped when RELU_EN = 1
//   done                frame complete, sticky until next start
// ---------------------------------------------------------------------------
module ofmap_writer_param_2 #(
   parameter int DATA_WIDTH        = 16,
   parameter int OUT_FEATURE_WIDTH = 12,
   parameter int NUM_OUT_MAPS      = 4,
   parameter int COL_WIDTH         = 4,
   parameter int MAP_WIDTH         = 2,
   parameter int OUT_ADDR_WIDTH    = 10,
   parameter int RELU_EN           = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   ofmap_writer_param_2_if.slave   bus,
   output logic                    done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Last index of each counter, sized to the counter itself.
   localparam logic [COL_WIDTH-1:0] POS_LAST = COL_WIDTH'(OUT_FEATURE_WIDTH - 1);
   localparam logic [MAP_WIDTH-1:0] MAP_LAST = MAP_WIDTH'(NUM_OUT_MAPS - 1);

   // Strides at full address width so the products never truncate.
   localparam logic [OUT_ADDR_WIDTH-1:0] ROW_STRIDE =
      OUT_ADDR_WIDTH'(OUT_FEATURE_WIDTH);
   localparam logic [OUT_ADDR_WIDTH-1:0] MAP_STRIDE =
      OUT_ADDR_WIDTH'(OUT_FEATURE_WIDTH * OUT_FEATURE_WIDTH);

   // ReLU: a negative two's-complement result is written as zero.
   function automatic logic [DATA_WIDTH-1:0] relu_clamp(
      input logic signed [DATA_WIDTH-1:0] x
   );
      if ((RELU_EN != 0) && (x < 0))
         return '0;
      return $unsigned(x);
   endfunction

   state_t                    state_q, state_d;
   logic [COL_WIDTH-1:0]      col_q, col_d;
   logic [COL_WIDTH-1:0]      row_q, row_d;
   logic [MAP_WIDTH-1:0]      map_q, map_d;
   logic                      we_q, we_d;
   logic [OUT_ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic                      done_q, done_d;

   logic                      in_ready;
   logic                      accept;
   logic [OUT_ADDR_WIDTH-1:0] addr_now;
   logic signed [DATA_WIDTH-1:0] in_data_s;

   assign in_ready  = (state_q == ST_WRITE);
   assign accept    = bus.in_valid & in_ready;
   assign in_data_s = bus.in_data;

   assign addr_now = OUT_ADDR_WIDTH'(map_q) * MAP_STRIDE
                   + OUT_ADDR_WIDTH'(row_q) * ROW_STRIDE
                   + OUT_ADDR_WIDTH'(col_q);

   // ---- next-state: FSM, counters and write-port registers ----
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      map_d   = map_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      done_d  = done_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            // The start cycle itself never accepts a beat (in_ready is low).
            if (start) begin
               state_d = ST_WRITE;
               col_d   = '0;
               row_d   = '0;
               map_d   = '0;
               done_d  = 1'b0;
            end
         end

         ST_WRITE: begin
            // start is deliberately ignored here.
            if (accept) begin
               we_d    = 1'b1;
               waddr_d = addr_now;
               wdata_d = relu_clamp(in_data_s);

               if (col_q != POS_LAST) begin
                  col_d = col_q + 1'b1;
               end else begin
                  col_d = '0;
                  if (row_q != POS_LAST) begin
                     row_d = row_q + 1'b1;
                  end else begin
                     row_d = '0;
                     if (map_q != MAP_LAST) begin
                        map_d = map_q + 1'b1;
                     end else begin
                        // Final pixel: done rises alongside this write.
                        map_d   = '0;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                     end
                  end
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---- register stage: write port visible one cycle after accept ----
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         col_q   <= '0;
         row_q   <= '0;
         map_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         map_q   <= map_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.we       = we_q;
   assign bus.waddr    = waddr_q;
   assign bus.wdata    = wdata_q;
   assign done         = done_q;

endmodule

// File: tb/tb_ofmap_writer_param_2.sv
// ---------------------------------------------------------------------------
// tb_ofmap_writer_param_2
// Directed bench for the output feature-map writer (W=12, 4 maps, ReLU on).
// ---------------------------------------------------------------------------
module tb_ofmap_writer_param_2;

   localparam int DW = 16;
   localparam int AW = 10;
   localparam int W  = 12;
   localparam int NM = 4;
   localparam int FRAME = W * W * NM;

   logic clk;
   logic reset;
   logic start;
   logic done;

   ofmap_writer_param_2_if #(.DATA_WIDTH(DW), .OUT_ADDR_WIDTH(AW)) bus ();

   ofmap_writer_param_2 #(
      .DATA_WIDTH(DW), .OUT_FEATURE_WIDTH(W), .NUM_OUT_MAPS(NM),
      .COL_WIDTH(4), .MAP_WIDTH(2), .OUT_ADDR_WIDTH(AW), .RELU_EN(1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bus   (bus.slave),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   typedef struct {
      logic          start;
      logic          vld;
      logic [DW-1:0] data;
      logic          exp_we;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_wdata;
   } vec_t;

   vec_t tbl [12];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int next_addr;

      tbl[0]  = '{1'b0, 1'b1, 16'hFFF0, 1'b1, 10'd0, 16'h0000};
      tbl[1]  = '{1'b0, 1'b0, 16'h1234, 1'b0, 10'd0, 16'h0000};
      tbl[2]  = '{1'b0, 1'b0, 16'h1234, 1'b0, 10'd0, 16'h0000};
      tbl[3]  = '{1'b0, 1'b1, 16'h7FFF, 1'b1, 10'd1, 16'h7FFF};
      tbl[4]  = '{1'b0, 1'b1, 16'h8000, 1'b1, 10'd2, 16'h0000};
      tbl[5]  = '{1'b1, 1'b1, 16'h0005, 1'b1, 10'd3, 16'h0005};
      tbl[6]  = '{1'b1, 1'b0, 16'h0006, 1'b0, 10'd3, 16'h0005};
      tbl[7]  = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 10'd4, 16'h0000};
      tbl[8]  = '{1'b0, 1'b1, 16'h0100, 1'b1, 10'd5, 16'h0100};
      tbl[9]  = '{1'b0, 1'b0, 16'h0200, 1'b0, 10'd5, 16'h0100};
      tbl[10] = '{1'b0, 1'b1, 16'h0007, 1'b1, 10'd6, 16'h0007};
      tbl[11] = '{1'b0, 1'b1, 16'h7FFF, 1'b1, 10'd7, 16'h7FFF};

      reset        = 1'b1;
      start        = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h00AA;

      // Reset held 3 cycles with in_valid high.
      repeat (3) tick();
      check("rst_we",    bus.we,       0);
      check("rst_waddr", bus.waddr,    0);
      check("rst_wdata", bus.wdata,    0);
      check("rst_done",  done,         0);
      check("rst_ready", bus.in_ready, 0);

      // Start from IDLE; the start cycle must not accept the valid beat.
      reset       = 1'b0;
      start       = 1'b1;
      bus.in_data = 16'd99;
      tick();
      start = 1'b0;
      check("start_no_accept_we", bus.we,       0);
      check("start_ready",        bus.in_ready, 1);
      check("start_done",         done,         0);

      // Full frame, back-to-back beats with data = k.
      for (int k = 0; k < FRAME; k++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = DW'(k);
         tick();
         check($sformatf("frame_we_%0d", k),    bus.we,    1);
         check($sformatf("frame_addr_%0d", k),  bus.waddr, k);
         check($sformatf("frame_wdata_%0d", k), bus.wdata, k);
         check($sformatf("frame_done_%0d", k),  done, (k == FRAME - 1) ? 1 : 0);
      end

      // DONE: further valid beats are refused and the outputs hold.
      bus.in_data = 16'h0BAD;
      tick();
      check("done_we",    bus.we,       0);
      check("done_ready", bus.in_ready, 0);
      check("done_hold",  done,         1);
      check("done_addr",  bus.waddr,    FRAME - 1);

      // New frame from DONE.
      bus.in_valid = 1'b0;
      start        = 1'b1;
      tick();
      start = 1'b0;
      check("restart_done",  done,         0);
      check("restart_ready", bus.in_ready, 1);
      check("restart_we",    bus.we,       0);

      // Bubbles, ReLU clamp and start-during-WRITE from the vector table.
      for (int i = 0; i < 12; i++) begin
         start        = tbl[i].start;
         bus.in_valid = tbl[i].vld;
         bus.in_data  = tbl[i].data;
         tick();
         check($sformatf("tbl%0d_we", i),    bus.we,       tbl[i].exp_we);
         check($sformatf("tbl%0d_addr", i),  bus.waddr,    tbl[i].exp_addr);
         check($sformatf("tbl%0d_wdata", i), bus.wdata,    tbl[i].exp_wdata);
         check($sformatf("tbl%0d_ready", i), bus.in_ready, 1);
         check($sformatf("tbl%0d_done", i),  done,         0);
      end
      start = 1'b0;

      // Continue to beat 50, then reset mid-frame.
      next_addr = 8;
      while (next_addr <= 50) begin
         bus.in_valid = 1'b1;
         bus.in_data  = DW'(next_addr);
         tick();
         check($sformatf("pre_rst_addr_%0d", next_addr), bus.waddr, next_addr);
         next_addr++;
      end

      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_we",    bus.we,       0);
      check("midrst_waddr", bus.waddr,    0);
      check("midrst_wdata", bus.wdata,    0);
      check("midrst_ready", bus.in_ready, 0);
      check("midrst_done",  done,         0);

      // Back in IDLE: valid alone does nothing.
      tick();
      check("idle_we",    bus.we,       0);
      check("idle_ready", bus.in_ready, 0);

      start        = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      start = 1'b0;
      check("rec_ready", bus.in_ready, 1);

      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0055;
      tick();
      check("rec_we",    bus.we,    1);
      check("rec_addr",  bus.waddr, 0);
      check("rec_wdata", bus.wdata, 16'h0055);
      check("rec_done",  done,      0);

      bus.in_valid = 1'b1;
      bus.in_data  = 16'h0066;
      tick();
      check("rec2_addr", bus.waddr, 1);

      bus.in_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
